apb_master: RTL and testbench

- Single-outstanding APB-style bus master that turns simple request/response commands into sel/enable transfers toward the APB slave stage.
- The slave stage then converts those transfers into memory-bus reads and writes.
- Sits directly upstream of the slave. Consumes commands from the test sequencer or I2C front end. Returns read data and a completion/error response.
- Adds a bounded wait-for-ready timeout so a stalled slave cannot hang the bus.

---
 rtl/apb_master.sv | 119 +++++++++++
 tb/tb_apb_master.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB master with bounded wait-for-ready timeout
// Ports: clk/reset (sync, active-low); req_* command in with req_ready handshake;
//        resp_valid/resp_error/resp_rdata completion pulse; sel/enable/write/addr/
//        wdata/waits toward the slave; ready/rdata back from the slave.
module apb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [7:0]        req_waits,
  output logic              resp_valid,
  output logic              resp_error,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              sel,
  output logic              enable,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic [7:0]        waits,
  input  logic              ready,
  input  logic [DATA_W-1:0] rdata
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state_q, state_d;
  logic req_ready_q, req_ready_d, sel_q, sel_d, enable_q, enable_d, write_q, write_d;
  logic resp_valid_q, resp_valid_d, resp_error_q, resp_error_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, resp_rdata_q, resp_rdata_d;
  logic [7:0] waits_q, waits_d, cnt_q, cnt_d;
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    enable_d     = enable_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    waits_d      = waits_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      IDLE: if (req_valid && req_ready_q) begin
        write_d  = req_write;
        addr_d   = req_addr;
        wdata_d  = req_wdata;
        waits_d  = req_waits;
        sel_d    = 1'b1;
        enable_d = 1'b0;
        state_d  = SETUP;
      end
      SETUP: begin
        enable_d = 1'b1;
        cnt_d    = 8'd0;
        state_d  = ACCESS;
      end
      ACCESS: begin
        // ready is checked first so a coincident timeout still completes normally
        if (ready || cnt_q == 8'(TIMEOUT - 1)) begin
          resp_valid_d = 1'b1;
          resp_error_d = !ready;
          resp_rdata_d = !ready ? '0 : write_q ? resp_rdata_q : rdata;
          sel_d        = 1'b0;
          enable_d     = 1'b0;
          state_d      = IDLE;
        end else
          cnt_d = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      sel_q        <= 1'b0;
      enable_q     <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      waits_q      <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      sel_q        <= sel_d;
      enable_q     <= enable_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      waits_q      <= waits_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end
  assign req_ready  = req_ready_q;
  assign sel        = sel_q;
  assign enable     = enable_q;
  assign write      = write_q;
  assign addr       = addr_q;
  assign wdata      = wdata_q;
  assign waits      = waits_q;
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed bench with transaction-level model and memory-backed slave
module tb_apb_master;
  localparam int TO = 64;
  logic clk = 0, reset = 0;
  logic req_valid = 0, req_write = 0, req_ready;
  logic [7:0] req_addr = 0, req_wdata = 0, req_waits = 0;
  logic resp_valid, resp_error, sel, enable, write, ready;
  logic [7:0] resp_rdata, addr, wdata, waits, rdata;
  logic stall = 0;
  int n_cmp = 0, n_bad = 0;
  apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_waits(req_waits),
    .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
    .sel(sel), .enable(enable), .write(write), .addr(addr), .wdata(wdata), .waits(waits),
    .ready(ready), .rdata(rdata));
  always #5 clk = ~clk;
  logic [7:0] mem [256];
  logic [7:0] acc_cnt = 0;
  initial foreach (mem[i]) mem[i] = 8'h00;
  assign ready = sel && enable && !stall && acc_cnt == waits;
  assign rdata = mem[addr];
  always @(posedge clk) begin
    acc_cnt <= (sel && enable && !ready) ? acc_cnt + 8'd1 : 8'd0;
    if (sel && enable && ready && write) mem[addr] <= wdata;
  end
  logic [7:0] mm [256];
  initial foreach (mm[i]) mm[i] = 8'h00;
  logic armed = 0, m_busy = 0, m_rr = 0, m_sel = 0, m_en = 0, m_w = 0;
  logic m_rv = 0, m_re = 0, m_err = 0;
  logic [7:0] m_a = 0, m_d = 0, m_wt = 0, m_rd = 0;
  int m_t = 0, m_len = 0;
  always @(posedge clk) begin
    armed <= 1;
    m_rv  <= 0;
    m_re  <= 0;
    if (!reset) begin
      m_busy <= 0; m_rr <= 0; m_sel <= 0; m_en <= 0; m_w <= 0;
      m_a <= 0; m_d <= 0; m_wt <= 0; m_rd <= 0;
    end else if (m_busy) begin
      if (m_t == m_len) begin
        m_busy <= 0; m_rr <= 1; m_sel <= 0; m_en <= 0; m_rv <= 1; m_re <= m_err;
        m_rd <= m_err ? 8'h00 : m_w ? m_rd : mm[m_a];
        if (!m_err && m_w) mm[m_a] <= m_d;
      end else begin
        m_t  <= m_t + 1;
        m_en <= 1;
      end
    end else if (req_valid && m_rr) begin
      m_busy <= 1; m_rr <= 0; m_sel <= 1; m_en <= 0; m_t <= 0;
      m_w <= req_write; m_a <= req_addr; m_d <= req_wdata; m_wt <= req_waits;
      m_err <= stall || int'(req_waits) >= TO;
      m_len <= (stall || int'(req_waits) >= TO) ? TO : int'(req_waits) + 1;
    end else
      m_rr <= 1;
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  always @(negedge clk) if (armed) begin
    chk("req_ready", req_ready, m_rr);
    chk("sel", sel, m_sel);
    chk("enable", enable, m_en);
    chk("write", write, m_w);
    chk("addr", addr, m_a);
    chk("wdata", wdata, m_d);
    chk("waits", waits, m_wt);
    chk("resp_valid", resp_valid, m_rv);
    chk("resp_error", resp_error, m_re);
    chk("resp_rdata", resp_rdata, m_rd);
  end
  int sel_run = 0, en_run = 0, last_sel = 0, last_en = 0, n_resp = 0;
  logic last_err = 0;
  logic [7:0] last_rd = 0;
  always @(negedge clk) begin
    if (!reset) begin
      sel_run = 0; en_run = 0;
    end else begin
      if (sel) sel_run++;
      if (enable) en_run++;
      if (resp_valid) begin
        last_sel = sel_run; last_en = en_run; last_err = resp_error; last_rd = resp_rdata;
        n_resp++; sel_run = 0; en_run = 0;
      end
    end
  end
  task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] wt, input bit hold);
    int i;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_waits = wt;
    for (i = 0; i < 300 && !req_ready; i++) @(negedge clk);
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_wait: got no req_ready expected req_ready within 300 cycles");
    end
    @(negedge clk);
    if (!hold) begin
      req_valid = 0; req_write = ~w; req_addr = ~a; req_wdata = ~d; req_waits = 8'hff;
    end
  endtask
  task automatic wait_resp();
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (resp_valid) break;
    end
    if (i == 300) begin
      n_cmp++; n_bad++;
      $display("FAIL resp_wait: got no resp_valid expected resp_valid within 300 cycles");
    end
    #1;
  endtask
  initial begin
    int nr;
    @(negedge clk);
    chk("rst_sel", sel, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("req_ready_after_rst", req_ready, 1);
    send(1, 8'h12, 8'hA5, 8'd0, 0);
    wait_resp();
    chk("wr_sel_cycles", last_sel, 2);
    chk("wr_en_cycles", last_en, 1);
    chk("wr_err", last_err, 0);
    chk("wr_mem", mem[8'h12], 8'hA5);
    send(0, 8'h12, 8'h00, 8'd3, 0);
    wait_resp();
    chk("rd_en_cycles", last_en, 4);
    chk("rd_data", last_rd, 8'hA5);
    chk("rd_err", last_err, 0);
    stall = 1;
    send(0, 8'h12, 8'h00, 8'd0, 0);
    wait_resp();
    chk("to_err", last_err, 1);
    chk("to_en_cycles", last_en, TO);
    chk("to_rdata", last_rd, 0);
    chk("to_sel_low", sel, 0);
    chk("to_req_ready", req_ready, 1);
    stall = 0;
    @(negedge clk);
    send(1, 8'h40, 8'h5A, 8'(TO - 1), 0);
    wait_resp();
    chk("edge_err", last_err, 0);
    chk("edge_en_cycles", last_en, TO);
    chk("edge_mem", mem[8'h40], 8'h5A);
    nr = n_resp;
    send(1, 8'h01, 8'h10, 8'd0, 1);
    send(0, 8'h01, 8'h00, 8'd0, 0);
    wait_resp();
    chk("b2b_resps", n_resp - nr, 2);
    chk("b2b_rdata", last_rd, 8'h10);
    nr = n_resp;
    send(1, 8'h33, 8'h77, 8'd5, 0);
    @(negedge clk);
    chk("abort_in_access", enable, 1);
    reset = 0;
    @(negedge clk);
    chk("abort_sel", sel, 0);
    chk("abort_enable", enable, 0);
    reset = 1;
    repeat (10) @(negedge clk);
    chk("abort_no_resp", n_resp - nr, 0);
    chk("abort_mem", mem[8'h33], 8'h00);
    chk("abort_idle", req_ready, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
